// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, states and mux codes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMMSL2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: counts stalled request cycles and flags the timeout.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    // Clear wins over increment; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = 8'd0;
        else if (inc) cnt_d = cnt_q + 8'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    // Fires on the stalled cycle that would bring the count to WAIT_MAX.
    // An ack in that cycle drops inc, so a last-moment ack is honoured.
    assign expired = inc && (cnt_q == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       fault,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    logic   pending, ack_v, entering, tmr_clr, tmr_inc, expired;
    logic   pc_write, pc_write_cond;

    // Only acks during an outstanding request mean anything.
    assign pending  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign ack_v    = pending && mem_ack;
    assign entering = (state_d != state_q) &&
                      ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR));
    assign tmr_inc  = pending && !mem_ack;
    assign tmr_clr  = ack_v || entering;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore output decode; everything forced low while in reset.
    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        fault         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
                if (mem_ack)      state_d = S_DECODE;
                else if (expired) state_d = S_FAULT;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSL2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ack)      state_d = S_MEMWB;
                else if (expired) state_d = S_FAULT;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ack)      state_d = S_FETCH;
                else if (expired) state_d = S_FAULT;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_FAULT;
        endcase
        pc_en = pc_write || (pc_write_cond && zero);
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            i_or_d     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_B;
            alu_op     = ALU_ADD;
            pc_source  = PCSRC_ALU;
            fault      = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, 15, memory-wait cycles tolerated before fault (legal range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ack  in  1  memory completion; valid only while mem_read or mem_write is high.
REQ-007 mem_read, mem_write  out  1 each  memory request; held until mem_ack.
REQ-008 ir_write  out  1  instruction register load strobe.
REQ-009 pc_en  out  1  PC load enable; equals pc_write OR (pc_write_cond AND zero).
REQ-010 i_or_d  out  1  memory address select (0 = PC, 1 = ALUOut).
REQ-011 reg_dst  out  1  write-register 5-bit mux select (0 = rt, 1 = rd).
REQ-012 mem_to_reg  out  1  write-data 32-bit mux select (0 = ALUOut, 1 = MDR).
REQ-013 reg_write  out  1  register file write strobe.
REQ-014 alu_src_a  out  1  (0 = PC, 1 = A); alu_src_b  out  2  (0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2).
REQ-015 alu_op  out  2  (0 = add, 1 = sub, 2 = funct-decoded); pc_source  out  2  (0 = ALU, 1 = ALUOut, 2 = jump target).
REQ-016 fault  out  1  sticky error flag; state_o  out  4  current state, for debug.

Function
REQ-017 Decoded opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02; any other opcode is illegal.
REQ-018 States, 4-bit encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, FAULT 12.
REQ-019 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; on mem_ack, ir_write=1 and pc_write=1 in that same cycle, next state DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0; next state by opcode: lw/sw -> MEMADR, R-type -> RTEX, beq -> BEQ, addi -> ADDIEX, j -> JUMP, illegal -> FETCH with no architectural write.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0; next state MEMRD for lw, MEMWR for sw.
REQ-022 MEMRD: mem_read=1, i_or_d=1; on mem_ack -> MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-023 MEMWR: mem_write=1, i_or_d=1; on mem_ack -> FETCH.
REQ-024 RTEX: alu_src_a=1, alu_src_b=0, alu_op=2; next state RTWB. RTWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-025 BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1; next state FETCH.
REQ-026 ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0; next state ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-027 JUMP: pc_write=1, pc_source=2; next state FETCH.
REQ-028 Output timing: all outputs are Moore decodes of state, except ir_write and pc_write in FETCH, which are qualified combinationally by mem_ack.
REQ-029 Outputs not listed for a state are 0.
REQ-030 Wait counter (8-bit):
- clears on entry to FETCH, MEMRD or MEMWR, and on every mem_ack;
- increments each cycle a request is pending without mem_ack;
- when it reaches WAIT_MAX with no ack, next state is FAULT.
REQ-031 mem_ack arriving in the same cycle the counter reaches WAIT_MAX is honoured: normal transition, no fault.
REQ-032 FAULT: all strobes 0, fault=1; the state is absorbing until reset.
REQ-033 mem_ack sampled in any state without an active request is ignored.

Reset
REQ-034 rst_n low forces, asynchronously: state FETCH, wait counter 0, fault 0.
REQ-035 While rst_n is low, all strobe outputs SHALL be 0 (mem_read, ir_write, pc_en, reg_write, mem_write forced low).
REQ-036 Reset asserted mid-instruction abandons the instruction; no register or memory write completes after the assertion edge.
REQ-037 After rst_n deasserts, the first rising edge begins a fetch with mem_read=1.

Structure
REQ-038 Shared package mc_pkg holds: opcode constants, state encoding, alu_op codes, alu_src_b codes, pc_source codes.
REQ-039 Sub-module mc_wait_timer holds the wait counter and timeout compare, with inputs clr and inc and output expired.
REQ-040 multicycle_ctrl holds only the state register, next-state logic and output decode.

Verification
REQ-041 lw, ack after 2 wait cycles each access -> state sequence 0,0,0,1,2,3,3,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1 and reg_dst=0.
REQ-042 beq with zero=1 -> pc_en=1 in BEQ with pc_source=1; repeat with zero=0 -> pc_en=0 in BEQ.
REQ-043 sw with mem_ack never asserted, WAIT_MAX=15 -> FAULT entered 15 cycles after MEMWR entry; fault stays 1 under further acks until rst_n low.
REQ-044 Opcode 0x3F -> DECODE returns to FETCH; reg_write, mem_write and pc_en stay 0 throughout.
REQ-045 rst_n pulsed low asynchronously during RTEX -> outputs 0 immediately; no RTWB write; fetch restarts after release.
REQ-046 mem_ack arriving exactly on the WAIT_MAX-th cycle in FETCH -> DECODE reached and fault stays 0.
